// File: rtl/wb_trace_pkg.sv
// Record layout and pack/unpack helpers shared by the Wishbone trace monitor.
// Record is {ts, we, sel, adr[ADDR_W-1:0], data}, with data in the least significant bits.
package wb_trace_pkg;

  localparam int DATA_W    = 32;
  localparam int SEL_W     = 4;
  localparam int DROP_W    = 16;
  localparam int TS_MAX_W  = 32;
  localparam int ADR_MAX_W = 32;
  localparam int REC_MAX_W = TS_MAX_W + 1 + SEL_W + ADR_MAX_W + DATA_W;

  typedef struct packed {
    logic [TS_MAX_W-1:0]  ts;
    logic                 we;
    logic [SEL_W-1:0]     sel;
    logic [ADR_MAX_W-1:0] adr;
    logic [DATA_W-1:0]    dat;
  } rec_t;

  function automatic int rec_width(input int ts_w, input int addr_w);
    return ts_w + 1 + SEL_W + addr_w + DATA_W;
  endfunction

  function automatic int off_adr();
    return DATA_W;
  endfunction

  function automatic int off_sel(input int addr_w);
    return DATA_W + addr_w;
  endfunction

  function automatic int off_we(input int addr_w);
    return DATA_W + addr_w + SEL_W;
  endfunction

  function automatic int off_ts(input int addr_w);
    return DATA_W + addr_w + SEL_W + 1;
  endfunction

  function automatic logic [31:0] field_mask(input int w);
    return 32'hFFFF_FFFF >> (32 - w);
  endfunction

  // Fields narrower than 32 bits are truncated to their configured width.
  function automatic logic [REC_MAX_W-1:0] rec_pack(
    input int ts_w, input int addr_w,
    input logic [TS_MAX_W-1:0] ts, input logic we, input logic [SEL_W-1:0] sel,
    input logic [ADR_MAX_W-1:0] adr, input logic [DATA_W-1:0] dat);
    logic [REC_MAX_W-1:0] r;
    r = REC_MAX_W'(dat);
    r = r | (REC_MAX_W'(adr & field_mask(addr_w)) << off_adr());
    r = r | (REC_MAX_W'(sel) << off_sel(addr_w));
    r = r | (REC_MAX_W'(we) << off_we(addr_w));
    r = r | (REC_MAX_W'(ts & field_mask(ts_w)) << off_ts(addr_w));
    return r;
  endfunction

  function automatic rec_t rec_unpack(input int ts_w, input int addr_w,
                                      input logic [REC_MAX_W-1:0] r);
    rec_t u;
    u.dat = r[DATA_W-1:0];
    u.adr = ADR_MAX_W'(r >> off_adr()) & field_mask(addr_w);
    u.sel = SEL_W'(r >> off_sel(addr_w));
    u.we  = r[off_we(addr_w)];
    u.ts  = TS_MAX_W'(r >> off_ts(addr_w)) & field_mask(ts_w);
    return u;
  endfunction

endpackage

// File: rtl/trace_ring.sv
// Circular record store with show-ahead head; push lands next cycle, pop advances head next cycle.
// No backpressure: push when full either drops (o_drop) or overwrites the oldest entry (o_ovwr).
module trace_ring #(
  parameter  int DEPTH = 16,
  parameter  int REC_W = 85,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             i_clk,
  input  logic             i_clr,
  input  logic             i_push,
  input  logic             i_wrap,
  input  logic             i_pop,
  input  logic [REC_W-1:0] i_rec,
  output logic             o_valid,
  output logic [REC_W-1:0] o_rec,
  output logic [CNT_W-1:0] o_count,
  output logic [CNT_W-1:0] o_count_nxt,
  output logic             o_drop,
  output logic             o_ovwr
);

  logic [REC_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_valid;

  logic w_pop;
  logic w_full;
  logic w_wr;
  logic w_grow;

  always_comb begin
    w_pop       = i_pop & r_valid;
    // A pop in the same cycle frees a slot, so the buffer is not full then.
    w_full      = (r_count == CNT_W'(DEPTH)) & ~w_pop;
    w_wr        = i_push & (~w_full | i_wrap);
    o_ovwr      = i_push & w_full & i_wrap;
    o_drop      = i_push & w_full & ~i_wrap;
    w_grow      = w_wr & ~o_ovwr;
    o_count_nxt = r_count;
    if (w_grow & ~w_pop) begin
      o_count_nxt = r_count + CNT_W'(1);
    end else if (~w_grow & w_pop) begin
      o_count_nxt = r_count - CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop | o_ovwr) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= o_count_nxt;
      r_valid <= (o_count_nxt != '0);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr & ~i_clr) begin
      r_mem[r_wr_ptr] <= i_rec;
    end
  end

  assign o_valid = r_valid;
  assign o_rec   = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/wb_trace_monitor.sv
// Passive Wishbone tracer: filtered, timestamped records of acked transfers into a ring buffer.
// Hit in cycle N is visible from N+1; there is no backpressure, so a full buffer drops or overwrites.
module wb_trace_monitor
  import wb_trace_pkg::*;
#(
  parameter  int DEPTH      = 16,
  parameter  int ADDR_W     = 16,
  parameter  int TS_W       = 16,
  parameter  int IRQ_THRESH = DEPTH / 2,
  localparam int REC_W      = TS_W + 1 + 4 + ADDR_W + 32,
  localparam int CNT_W      = $clog2(DEPTH) + 1
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              mon_cyc_i,
  input  logic              mon_stb_i,
  input  logic              mon_we_i,
  input  logic              mon_ack_i,
  input  logic [3:0]        mon_sel_i,
  input  logic [31:0]       mon_adr_i,
  input  logic [31:0]       mon_dat_w_i,
  input  logic [31:0]       mon_dat_r_i,
  input  logic              cfg_en_i,
  input  logic              cfg_wrap_i,
  input  logic [31:0]       cfg_match_i,
  input  logic [31:0]       cfg_mask_i,
  input  logic              cfg_clear_i,
  input  logic              rd_pop_i,
  output logic              rd_valid_o,
  output logic [REC_W-1:0]  rd_data_o,
  output logic [CNT_W-1:0]  count_o,
  output logic [DROP_W-1:0] drop_cnt_o,
  output logic              overflow_o,
  output logic              irq_o
);

  logic [TS_W-1:0]   r_ts;
  logic [DROP_W-1:0] r_drop;
  logic              r_ovf;
  logic              r_irq;

  logic              w_clr;
  logic              w_hit;
  logic [31:0]       w_dat;
  logic [REC_W-1:0]  w_rec;
  logic [CNT_W-1:0]  w_count_nxt;
  logic              w_drop;
  logic              w_ovwr;

  assign w_clr = wb_rst_i | cfg_clear_i;
  assign w_hit = mon_cyc_i & mon_stb_i & mon_ack_i & cfg_en_i &
                 (((mon_adr_i ^ cfg_match_i) & cfg_mask_i) == 32'h0);
  assign w_dat = mon_we_i ? mon_dat_w_i : mon_dat_r_i;
  assign w_rec = REC_W'(rec_pack(TS_W, ADDR_W, TS_MAX_W'(r_ts), mon_we_i, mon_sel_i,
                                 mon_adr_i, w_dat));

  trace_ring #(
    .DEPTH (DEPTH),
    .REC_W (REC_W)
  ) u_ring (
    .i_clk       (wb_clk_i),
    .i_clr       (w_clr),
    .i_push      (w_hit),
    .i_wrap      (cfg_wrap_i),
    .i_pop       (rd_pop_i),
    .i_rec       (w_rec),
    .o_valid     (rd_valid_o),
    .o_rec       (rd_data_o),
    .o_count     (count_o),
    .o_count_nxt (w_count_nxt),
    .o_drop      (w_drop),
    .o_ovwr      (w_ovwr)
  );

  always_ff @(posedge wb_clk_i) begin
    if (w_clr) begin
      r_ts   <= '0;
      r_drop <= '0;
      r_ovf  <= 1'b0;
      r_irq  <= 1'b0;
    end else begin
      r_ts <= r_ts + TS_W'(1);
      if (w_drop && (r_drop != {DROP_W{1'b1}})) begin
        r_drop <= r_drop + DROP_W'(1);
      end
      if (w_drop | w_ovwr) begin
        r_ovf <= 1'b1;
      end
      // Registered from the next fill level so irq_o tracks count_o cycle for cycle.
      r_irq <= (w_count_nxt >= CNT_W'(IRQ_THRESH));
    end
  end

  assign drop_cnt_o = r_drop;
  assign overflow_o = r_ovf;
  assign irq_o      = r_irq;

endmodule
